r200_pipe_ctl: RTL and testbench

- Pipeline sequencing controller for the r200 5-stage core: IF, ID, EX, MEM, WB.
- Sits beside the ID stage and watches the decoded instruction: register addresses, write-enable, load/branch/jump flags.
- Tracks in-flight destination registers in a small scoreboard.
- Drives the PC, IF/ID and ID/EX enables, bubbles and flushes, so the decode/regfile datapath never consumes a stale operand or a wrong-path instruction.

---
 rtl/r200_pipe_ctl_if.sv | 57 +++++
 rtl/r200_pipe_ctl.sv | 175 +++++++++++++++++
 tb/tb_r200_pipe_ctl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/r200_pipe_ctl_if.sv
// -----------------------------------------------------------------------------
// r200_pipe_ctl_if
//   Signal bundle between the r200 decode/datapath and the pipeline sequencing
//   controller.
//
//   Datapath -> controller (decoded ID-stage instruction plus EX/MEM status):
//     id_valid, id_rs1addr, id_rs2addr, id_use_rs1, id_use_rs2, id_regwr,
//     id_rdaddr, id_isload, id_isbr, id_willjmp, ex_taken, mem_req, dmem_ready
//   Controller -> datapath (stage enables, bubbles, redirects, status):
//     pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, pcsel_ovr,
//     mem_timeout, state
//
//   master : the datapath side (drives the decode/status signals)
//   slave  : the controller side (drives the sequencing controls)
// -----------------------------------------------------------------------------
interface r200_pipe_ctl_if;

   logic       id_valid;
   logic [4:0] id_rs1addr;
   logic [4:0] id_rs2addr;
   logic       id_use_rs1;
   logic       id_use_rs2;
   logic       id_regwr;
   logic [4:0] id_rdaddr;
   logic       id_isload;
   logic       id_isbr;
   logic       id_willjmp;
   logic       ex_taken;
   logic       mem_req;
   logic       dmem_ready;

   logic       pc_en;
   logic       ifid_en;
   logic       ifid_flush;
   logic       idex_bubble;
   logic       exmem_en;
   logic [1:0] pcsel_ovr;
   logic       mem_timeout;
   logic [1:0] state;

   modport master (
      output id_valid, id_rs1addr, id_rs2addr, id_use_rs1, id_use_rs2,
             id_regwr, id_rdaddr, id_isload, id_isbr, id_willjmp,
             ex_taken, mem_req, dmem_ready,
      input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
             pcsel_ovr, mem_timeout, state
   );

   modport slave (
      input  id_valid, id_rs1addr, id_rs2addr, id_use_rs1, id_use_rs2,
             id_regwr, id_rdaddr, id_isload, id_isbr, id_willjmp,
             ex_taken, mem_req, dmem_ready,
      output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
             pcsel_ovr, mem_timeout, state
   );

endinterface

// File: rtl/r200_pipe_ctl.sv
// -----------------------------------------------------------------------------
// r200_pipe_ctl
//   Pipeline sequencing controller for the r200 5-stage core (IF ID EX MEM WB).
//   Tracks in-flight destination registers in a three-slot scoreboard
//   (EX, MEM, WB) and drives PC / IF/ID / ID/EX / EX/MEM enables, bubbles,
//   flushes and PC-select overrides so ID never consumes a stale operand or a
//   wrong-path instruction.
//
//   Parameters
//     FWD_EN      1: EX/MEM forwarding exists, only load-use stalls.
//                 0: full interlock against EX, MEM and WB writers.
//     MEMWAIT_MAX cycles to wait for dmem_ready before mem_timeout fires.
//
//   Ports
//     clk  core clock
//     rst  asynchronous, active-high reset
//     bus  r200_pipe_ctl_if.slave (decode inputs in, sequencing controls out)
//
//   Outputs are combinational from the inputs and the registered scoreboard /
//   wait counter; state reports this cycle's mode:
//     00 RUN, 01 DSTALL, 10 FLUSH, 11 MWAIT.
// -----------------------------------------------------------------------------
module r200_pipe_ctl #(
   parameter bit          FWD_EN      = 1'b0,
   parameter int unsigned MEMWAIT_MAX = 15
) (
   input logic            clk,
   input logic            rst,
   r200_pipe_ctl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_DSTALL = 2'b01,
      ST_FLUSH  = 2'b10,
      ST_MWAIT  = 2'b11
   } state_t;

   // One in-flight instruction. isbr rides along so a taken branch can be
   // recognised while it sits in EX.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       isload;
      logic       isbr;
   } slot_t;

   localparam int unsigned     CW       = (MEMWAIT_MAX > 1) ? $clog2(MEMWAIT_MAX) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(MEMWAIT_MAX - 1);

   slot_t          ex_slot, mem_slot, wb_slot;
   logic [CW-1:0]  cnt_q;

   logic   rs1_hit, rs2_hit, hazard;
   logic   mem_wait, timeout_hit, branch_flush, jump;

   logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_timeout;
   logic [1:0] pcsel_ovr;
   state_t     state;

   function automatic logic slot_hit(slot_t s, logic [4:0] a);
      return s.valid && (s.rd == a);
   endfunction

   // Source match against the scoreboard; what counts as a match depends on
   // whether forwarding covers EX/MEM results.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (that would infer a latch).
      rs1_hit = 1'b0;
      rs2_hit = 1'b0;
      if (FWD_EN) begin
         rs1_hit = slot_hit(ex_slot, bus.id_rs1addr) && ex_slot.isload;
         rs2_hit = slot_hit(ex_slot, bus.id_rs2addr) && ex_slot.isload;
      end else begin
         rs1_hit = slot_hit(ex_slot,  bus.id_rs1addr) ||
                   slot_hit(mem_slot, bus.id_rs1addr) ||
                   slot_hit(wb_slot,  bus.id_rs1addr);
         rs2_hit = slot_hit(ex_slot,  bus.id_rs2addr) ||
                   slot_hit(mem_slot, bus.id_rs2addr) ||
                   slot_hit(wb_slot,  bus.id_rs2addr);
      end
      // x0 reads are hardwired zero and can never be stale.
      hazard = bus.id_valid &&
               ((bus.id_use_rs1 && (bus.id_rs1addr != 5'd0) && rs1_hit) ||
                (bus.id_use_rs2 && (bus.id_rs2addr != 5'd0) && rs2_hit));
   end

   assign mem_wait     = bus.mem_req && !bus.dmem_ready;
   // The last permitted waiting cycle is treated as completion.
   assign timeout_hit  = mem_wait && (cnt_q == CNT_LAST);
   assign branch_flush = ex_slot.isbr && bus.ex_taken;
   // A jump with a pending hazard stalls first and redirects once it clears.
   assign jump         = bus.id_valid && bus.id_willjmp && !hazard;

   // Priority: memory wait, taken branch, jump, data stall, run.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_en    = 1'b1;
      pcsel_ovr   = 2'b00;
      mem_timeout = 1'b0;
      state       = ST_RUN;
      // While reset is held the outputs sit at their reset values even if the
      // datapath still reports a pending memory access.
      if (!rst) begin
         if (mem_wait && !timeout_hit) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            state    = ST_MWAIT;
         end else begin
            mem_timeout = timeout_hit;
            if (branch_flush) begin
               // Wrong-path instructions sit in IF/ID and ID; kill both. Any
               // stall for the ID instruction is moot since it is discarded.
               pcsel_ovr   = 2'b10;
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               state       = ST_FLUSH;
            end else if (jump) begin
               pcsel_ovr  = 2'b01;
               ifid_flush = 1'b1;
               state      = ST_FLUSH;
            end else if (hazard) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_bubble = 1'b1;
               state       = ST_DSTALL;
            end
         end
      end
   end

   // NOTE: the scoreboard must be cleared by reset; stale valid bits left over
   // from before reset would stall the first instructions on phantom writers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_slot  <= '0;
         mem_slot <= '0;
         wb_slot  <= '0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments let the three slots shift in one
         // edge, each reading its neighbour's pre-edge value.
         if (mem_wait && !timeout_hit) cnt_q <= cnt_q + CW'(1);
         else                          cnt_q <= '0;

         if (exmem_en) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (idex_bubble) begin
               ex_slot <= '0;
            end else begin
               ex_slot.valid  <= bus.id_valid && bus.id_regwr && (bus.id_rdaddr != 5'd0);
               ex_slot.rd     <= bus.id_rdaddr;
               ex_slot.isload <= bus.id_valid && bus.id_isload;
               ex_slot.isbr   <= bus.id_valid && bus.id_isbr;
            end
         end
      end
   end

   assign bus.pc_en       = pc_en;
   assign bus.ifid_en     = ifid_en;
   assign bus.ifid_flush  = ifid_flush;
   assign bus.idex_bubble = idex_bubble;
   assign bus.exmem_en    = exmem_en;
   assign bus.pcsel_ovr   = pcsel_ovr;
   assign bus.mem_timeout = mem_timeout;
   assign bus.state       = state;

endmodule

// File: tb/tb_r200_pipe_ctl.sv
// -----------------------------------------------------------------------------
// tb_r200_pipe_ctl
//   Directed bench for r200_pipe_ctl. Two controllers share one stimulus:
//   u0 with full interlock (FWD_EN=0) and u1 with forwarding (FWD_EN=1).
//   Outputs are packed as {state, pc_en, ifid_en, ifid_flush, idex_bubble,
//   exmem_en, pcsel_ovr, mem_timeout}. Inputs change 1 time unit after the
//   rising edge; outputs are compared 2 units later.
// -----------------------------------------------------------------------------
module tb_r200_pipe_ctl;

   localparam logic [9:0] RUN_O = 10'b00_1_1_0_0_1_00_0;
   localparam logic [9:0] DST_O = 10'b01_0_0_0_1_1_00_0;
   localparam logic [9:0] FLB_O = 10'b10_1_1_1_1_1_10_0;
   localparam logic [9:0] JMP_O = 10'b00_1_1_1_0_1_01_0;  // state bits not compared
   localparam logic [9:0] MW_O  = 10'b11_0_0_0_0_0_00_0;
   localparam logic [9:0] TO_O  = 10'b00_1_1_0_0_1_00_1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   r200_pipe_ctl_if if0 ();
   r200_pipe_ctl_if if1 ();

   r200_pipe_ctl #(.FWD_EN(1'b0), .MEMWAIT_MAX(15)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   r200_pipe_ctl #(.FWD_EN(1'b1), .MEMWAIT_MAX(15)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

   function automatic logic [9:0] obs0();
      return {if0.state, if0.pc_en, if0.ifid_en, if0.ifid_flush, if0.idex_bubble,
              if0.exmem_en, if0.pcsel_ovr, if0.mem_timeout};
   endfunction

   function automatic logic [9:0] obs1();
      return {if1.state, if1.pc_en, if1.ifid_en, if1.ifid_flush, if1.idex_bubble,
              if1.exmem_en, if1.pcsel_ovr, if1.mem_timeout};
   endfunction

   task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1_, input logic u2_, input logic wr,
                         input logic [4:0] rd, input logic ld, input logic br,
                         input logic jmp);
      if0.id_valid = v;  if0.id_rs1addr = r1; if0.id_rs2addr = r2;
      if0.id_use_rs1 = u1_; if0.id_use_rs2 = u2_; if0.id_regwr = wr;
      if0.id_rdaddr = rd; if0.id_isload = ld; if0.id_isbr = br; if0.id_willjmp = jmp;
      if1.id_valid = v;  if1.id_rs1addr = r1; if1.id_rs2addr = r2;
      if1.id_use_rs1 = u1_; if1.id_use_rs2 = u2_; if1.id_regwr = wr;
      if1.id_rdaddr = rd; if1.id_isload = ld; if1.id_isbr = br; if1.id_willjmp = jmp;
   endtask

   task automatic set_ctl(input logic taken, input logic req, input logic rdy);
      if0.ex_taken = taken; if0.mem_req = req; if0.dmem_ready = rdy;
      if1.ex_taken = taken; if1.mem_req = req; if1.dmem_ready = rdy;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      set_ctl(1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b0;
   endtask

   // Reset values, reset during a stall and during a memory wait, x0 sources.
   task automatic test_reset();
      logic [9:0] got;
      rst = 1'b1;
      idle();
      set_ctl(1'b0, 1'b0, 1'b1);
      #2;
      got = obs0(); checks++;
      if (got !== RUN_O) begin errors++; $display("FAIL reset_u0: got %b want %b", got, RUN_O); end
      got = obs1(); checks++;
      if (got !== RUN_O) begin errors++; $display("FAIL reset_u1: got %b want %b", got, RUN_O); end
      tick();
      rst = 1'b0;

      // ADD x5 then ADD x6,x5,x1 -> stall, then reset mid-stall.
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      #2; tick();
      set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
      #2;
      got = obs0(); checks++;
      if (got !== DST_O) begin errors++; $display("FAIL rst_pre_stall: got %b want %b", got, DST_O); end
      rst = 1'b1;
      #1;
      got = obs0(); checks++;
      if (got !== RUN_O) begin errors++; $display("FAIL rst_in_stall: got %b want %b", got, RUN_O); end
      tick();
      rst = 1'b0;
      #1;
      got = obs0(); checks++;
      if (got !== RUN_O) begin errors++; $display("FAIL rst_sb_empty: got %b want %b", got, RUN_O); end
      tick();

      // Reset mid memory wait, with the request still pending.
      idle();
      set_ctl(1'b0, 1'b1, 1'b0);
      #2;
      got = obs0(); checks++;
      if (got !== MW_O) begin errors++; $display("FAIL rst_pre_mwait: got %b want %b", got, MW_O); end
      rst = 1'b1;
      #1;
      got = obs0(); checks++;
      if (got !== RUN_O) begin errors++; $display("FAIL rst_in_mwait: got %b want %b", got, RUN_O); end
      set_ctl(1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b0;

      // Writer of x0 followed by readers of x0: never a stall.
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      #2; tick();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
      #2;
      got = obs0(); checks++;
      if (got !== RUN_O) begin errors++; $display("FAIL x0_src: got %b want %b", got, RUN_O); end
      tick();
      idle();
   endtask

   // ADD x5 ; ADD x6,x5,x1: three stall cycles with interlock, none with forwarding.
   task automatic test_interlock();
      logic [9:0] got, exp;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         if (i == 0) set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
         else        set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
         #2;
         exp = (i == 0 || i == 4) ? RUN_O : DST_O;
         got = obs0(); checks++;
         if (got !== exp) begin errors++; $display("FAIL interlock_u0 cyc %0d: got %b want %b", i, got, exp); end
         got = obs1(); checks++;
         if (got !== RUN_O) begin errors++; $display("FAIL fwd_alu_u1 cyc %0d: got %b want %b", i, got, RUN_O); end
         tick();
      end
      idle();
   endtask

   // LW x5 ; ADD x6,x5,x0 with forwarding: exactly one stall cycle.
   task automatic test_load_use();
      logic [9:0] got, exp;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
         else        set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
         #2;
         exp = (i == 1) ? DST_O : RUN_O;
         got = obs1(); checks++;
         if (got !== exp) begin errors++; $display("FAIL load_use_u1 cyc %0d: got %b want %b", i, got, exp); end
         tick();
      end
      idle();
   endtask

   // ADD x5 ; BEQ ; (taken in EX) ADD x6,x5 pending stall is cancelled ; EX slot empty after.
   task automatic test_branch();
      logic [9:0] got, exp;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin set_ctl(1'b0, 1'b0, 1'b1);
                     set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); end
            1: begin set_ctl(1'b1, 1'b0, 1'b1);
                     set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); end
            2:       set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
            default: set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
         endcase
         #2;
         exp = (i == 2) ? FLB_O : RUN_O;
         got = obs0(); checks++;
         if (got !== exp) begin errors++; $display("FAIL branch_u0 cyc %0d: got %b want %b", i, got, exp); end
         if (i == 2) begin
            got = obs1(); checks++;
            if (got !== FLB_O) begin errors++; $display("FAIL branch_u1: got %b want %b", got, FLB_O); end
         end
         tick();
      end
      set_ctl(1'b0, 1'b0, 1'b1);
      idle();
   endtask

   // JAL x1 ; bubble ; ADD x2,x1,x0 stalls ; ADD x5 ; JALR on x5 stalls then redirects.
   task automatic test_jump();
      logic [9:0] got, exp;
      logic       is_jmp;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         case (i)
            0:       set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
            1:       idle();
            2, 3, 4: set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
            5:       set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
            default: set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1);
         endcase
         #2;
         is_jmp = (i == 0 || i == 9);
         exp = is_jmp ? JMP_O : ((i == 2 || i == 3 || i == 6 || i == 7 || i == 8) ? DST_O : RUN_O);
         got = obs0(); checks++;
         if (is_jmp) begin
            if (got[7:0] !== exp[7:0]) begin errors++; $display("FAIL jump_u0 cyc %0d: got %b want %b", i, got[7:0], exp[7:0]); end
         end else if (got !== exp) begin
            errors++; $display("FAIL jump_seq_u0 cyc %0d: got %b want %b", i, got, exp);
         end
         tick();
      end
      idle();
   endtask

   // 4 wait cycles then ready; then ready held low until the timeout fires.
   task automatic test_mem_wait();
      logic [9:0] got, exp;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_ctl(1'b0, 1'b1, (i == 4));
         #2;
         exp = (i == 4) ? RUN_O : MW_O;
         got = obs0(); checks++;
         if (got !== exp) begin errors++; $display("FAIL mwait cyc %0d: got %b want %b", i, got, exp); end
         tick();
      end
      for (int k = 1; k <= 16; k++) begin
         set_ctl(1'b0, 1'b1, 1'b0);
         #2;
         exp = (k == 15) ? TO_O : MW_O;
         got = obs0(); checks++;
         if (got !== exp) begin errors++; $display("FAIL timeout cyc %0d: got %b want %b", k, got, exp); end
         tick();
      end
      set_ctl(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      idle();
      set_ctl(1'b0, 1'b0, 1'b1);
      test_reset();
      test_interlock();
      test_load_use();
      test_branch();
      test_jump();
      test_mem_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
